// File: rtl/log2_pkg.sv
// Shared definitions for the fixed-point log2 unit: FSM encoding and the
// accumulator width and saturation limits derived from IW, FW and G.
package log2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_FRAC,
        S_ACC,
        S_OUT
    } state_t;

    // Limits come back at this fixed width; callers slice off the low OW bits.
    localparam int MAX_OW = 256;

    function automatic int calc_ow(input int iw, input int fw, input int g);
        return iw + fw + g;
    endfunction

    function automatic logic [MAX_OW-1:0] calc_minv(input int ow);
        return MAX_OW'(1) << (ow - 1);
    endfunction

    function automatic logic [MAX_OW-1:0] calc_maxv(input int ow);
        return (MAX_OW'(1) << (ow - 1)) - MAX_OW'(1);
    endfunction

endpackage

// File: rtl/log2_frac_step.sv
// One squaring iteration of the fractional log2 loop: squares the Q1.FW
// mantissa, emits one result bit and renormalises the square back into [1,2).
module log2_frac_step #(
    parameter int FW = 32
) (
    input  logic [FW:0] m_in,
    output logic        bit_out,
    output logic [FW:0] m_out
);

    logic [2*FW+1:0] m_ext;
    logic [2*FW+1:0] sq;

    // NOTE: combinational logic uses blocking '=' and assigns every output on
    // every path, so no latch can be inferred.
    always_comb begin
        m_ext   = {{(FW+1){1'b0}}, m_in};
        sq      = m_ext * m_ext;
        bit_out = sq[2*FW+1];
        m_out   = bit_out ? sq[2*FW+1:FW+1] : sq[2*FW:FW];
    end

endmodule

// File: rtl/log2_acc.sv
// Fixed-point log2 with optional saturating accumulation of log2 terms,
// handshaked on both sides; one operand in flight at a time.
module log2_acc
    import log2_pkg::*;
#(
    parameter  int IW    = 32,
    parameter  int FW    = 32,
    parameter  int G     = 8,
    parameter  int CNT_W = 16,
    localparam int W     = IW + FW,
    localparam int OW    = calc_ow(IW, FW, G)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iMode,
    input  logic [W-1:0]         iX,
    input  logic                 iLast,
    input  logic                 iValid,
    output logic                 oReady,
    output logic [OW-1:0]        oY,
    output logic [CNT_W-1:0]     oCount,
    output logic                 oNegInf,
    output logic                 oValid,
    input  logic                 iReady
);

    localparam int IPW = OW - FW;
    localparam int CW  = $clog2(W) + 1;
    localparam int KW  = $clog2(FW) + 1;

    localparam logic [MAX_OW-1:0] MINV_X = calc_minv(OW);
    localparam logic [MAX_OW-1:0] MAXV_X = calc_maxv(OW);
    localparam logic [OW-1:0]     MINV   = MINV_X[OW-1:0];
    localparam logic [OW-1:0]     MAXV   = MAXV_X[OW-1:0];

    state_t               state;
    logic [W-1:0]         sr;
    logic [CW-1:0]        c;
    logic [FW:0]          m;
    logic [FW-1:0]        frac;
    logic [KW-1:0]        k;
    logic                 mode_q;
    logic                 last_q;
    logic                 zero_q;
    logic signed [OW-1:0] acc_sum;
    logic [CNT_W-1:0]     acc_cnt;
    logic                 acc_neg;

    logic                 step_bit;
    logic [FW:0]          m_next;
    logic signed [31:0]   ip32;
    logic signed [OW-1:0] term;
    logic signed [OW:0]   sum_wide;
    logic signed [OW-1:0] sum_next;
    logic [CNT_W-1:0]     cnt_next;
    logic                 neg_next;

    log2_frac_step #(.FW(FW)) u_step (
        .m_in    (m),
        .bit_out (step_bit),
        .m_out   (m_next)
    );

    assign oReady = (state == S_IDLE);

    always_comb begin
        ip32     = 32'(IW - 1) - 32'(c);
        term     = zero_q ? MINV : {IPW'(ip32), frac};
        sum_wide = {acc_sum[OW-1], acc_sum} + {term[OW-1], term};
        // A zero anywhere in the sequence pins the sum at minus infinity.
        if (acc_neg || zero_q) begin
            sum_next = MINV;
        end else if (sum_wide[OW] != sum_wide[OW-1]) begin
            sum_next = sum_wide[OW] ? MINV : MAXV;
        end else begin
            sum_next = sum_wide[OW-1:0];
        end
        cnt_next = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1);
        neg_next = acc_neg | zero_q;
    end

    // NOTE: only control state, outputs and the accumulator are reset; the
    // datapath registers are always loaded before they are read.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= S_IDLE;
            oY      <= '0;
            oCount  <= '0;
            oNegInf <= 1'b0;
            oValid  <= 1'b0;
            acc_sum <= '0;
            acc_cnt <= '0;
            acc_neg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iValid) begin
                        sr     <= iX;
                        c      <= '0;
                        k      <= '0;
                        mode_q <= iMode;
                        last_q <= iLast;
                        zero_q <= (iX == '0);
                        state  <= (iX == '0) ? S_ACC : S_NORM;
                    end
                end
                S_NORM: begin
                    if (!sr[W-1]) begin
                        sr <= sr << 1;
                        c  <= c + CW'(1);
                    end else begin
                        m     <= sr[W-1 -: FW+1];
                        state <= S_FRAC;
                    end
                end
                S_FRAC: begin
                    m    <= m_next;
                    frac <= (frac << 1) | FW'(step_bit);
                    k    <= k + KW'(1);
                    if (k == KW'(FW - 1)) begin
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (!mode_q) begin
                        // Single-mode operands never touch an open sequence.
                        oY      <= term;
                        oCount  <= CNT_W'(1);
                        oNegInf <= zero_q;
                        oValid  <= 1'b1;
                        state   <= S_OUT;
                    end else if (last_q) begin
                        oY      <= sum_next;
                        oCount  <= cnt_next;
                        oNegInf <= neg_next;
                        oValid  <= 1'b1;
                        acc_sum <= '0;
                        acc_cnt <= '0;
                        acc_neg <= 1'b0;
                        state   <= S_OUT;
                    end else begin
                        acc_sum <= sum_next;
                        acc_cnt <= cnt_next;
                        acc_neg <= neg_next;
                        state   <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_log2_acc.sv
// Directed bench for log2_acc: default 32.32 instance for exact/irrational,
// zero, accumulate, backpressure and reset cases; a 4.4 instance swept fully.
module tb_log2_acc;

    localparam int W     = 64;
    localparam int OW    = 72;
    localparam int CNT_W = 16;
    localparam int SW    = 8;
    localparam int SOW   = 16;

    localparam logic [OW-1:0] MINV     = {1'b1, {(OW-1){1'b0}}};
    localparam logic [W-1:0]  X_ONE    = 64'h1_0000_0000;
    localparam logic [W-1:0]  X_TWO    = 64'h2_0000_0000;
    localparam logic [W-1:0]  X_THREE  = 64'h3_0000_0000;
    localparam logic [W-1:0]  X_FOUR   = 64'h4_0000_0000;
    localparam logic [W-1:0]  X_HALF   = 64'h0_8000_0000;
    localparam logic [OW-1:0] Y_ONE    = 72'h00_0000_0001_0000_0000;
    localparam logic [OW-1:0] Y_TWO    = 72'h00_0000_0002_0000_0000;
    localparam logic [OW-1:0] Y_M_ONE  = 72'hFF_FFFF_FFFF_0000_0000;

    logic iCLK = 1'b0;
    logic iRST;

    logic             iMode, iLast, iValid, iReady;
    logic [W-1:0]     iX;
    logic             oReady, oNegInf, oValid;
    logic [OW-1:0]    oY;
    logic [CNT_W-1:0] oCount;

    logic             s_mode, s_last, s_valid, s_iready;
    logic [SW-1:0]    s_x;
    logic             s_oready, s_neg, s_ovalid;
    logic [SOW-1:0]   s_y;
    logic [CNT_W-1:0] s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 iCLK = ~iCLK;

    log2_acc dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iMode   (iMode),
        .iX      (iX),
        .iLast   (iLast),
        .iValid  (iValid),
        .oReady  (oReady),
        .oY      (oY),
        .oCount  (oCount),
        .oNegInf (oNegInf),
        .oValid  (oValid),
        .iReady  (iReady)
    );

    log2_acc #(.IW(4), .FW(4), .G(8), .CNT_W(CNT_W)) dut_s (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iMode   (s_mode),
        .iX      (s_x),
        .iLast   (s_last),
        .iValid  (s_valid),
        .oReady  (s_oready),
        .oY      (s_y),
        .oCount  (s_cnt),
        .oNegInf (s_neg),
        .oValid  (s_ovalid),
        .iReady  (s_iready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Present an operand and return just after the edge that accepted it.
    task automatic send(input logic [W-1:0] x, input logic mode, input logic last);
        int n;
        n      = 0;
        iX     = x;
        iMode  = mode;
        iLast  = last;
        iValid = 1'b1;
        while (!oReady && n < 400) begin
            step();
            n++;
        end
        check("accept_ready", oReady, 1'b1);
        step();
        iValid = 1'b0;
    endtask

    // Cycle index of oValid, counting the cycle after the accept edge as 1.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!oValid && cyc < 400) begin
            step();
            cyc++;
        end
    endtask

    task automatic take();
        iReady = 1'b1;
        step();
        iReady = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [W-1:0] x,
                              input logic [OW-1:0] exp_y, input logic exp_neg,
                              input int exp_lat);
        int cyc;
        send(x, 1'b0, 1'b0);
        wait_valid(cyc);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_y"}, oY, exp_y);
        check({tag, "_cnt"}, oCount, 1);
        check({tag, "_neg"}, oNegInf, exp_neg);
        take();
    endtask

    // Accumulate a non-last sample: no output, oReady returns at exp_lat.
    task automatic acc_mid(input string tag, input logic [W-1:0] x, input int exp_lat);
        int   cyc;
        logic seen;
        send(x, 1'b1, 1'b0);
        cyc  = 1;
        seen = 1'b0;
        while (!oReady && cyc < 400) begin
            seen |= oValid;
            step();
            cyc++;
        end
        seen |= oValid;
        check({tag, "_ready_lat"}, cyc, exp_lat);
        check({tag, "_no_out"}, seen, 1'b0);
    endtask

    task automatic acc_last(input string tag, input logic [W-1:0] x,
                            input logic [OW-1:0] exp_y, input int exp_cnt,
                            input logic exp_neg, input int exp_lat);
        int cyc;
        send(x, 1'b1, 1'b1);
        wait_valid(cyc);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_y"}, oY, exp_y);
        check({tag, "_cnt"}, oCount, exp_cnt);
        check({tag, "_neg"}, oNegInf, exp_neg);
        take();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_y"}, oY, '0);
        check({tag, "_cnt"}, oCount, '0);
        check({tag, "_neg"}, oNegInf, 1'b0);
        check({tag, "_valid"}, oValid, 1'b0);
        check({tag, "_ready"}, oReady, 1'b1);
    endtask

    initial begin
        int   cyc;
        int   cyc_s;
        int   e;
        int   sy;
        real  r;
        logic stable;
        logic [OW-1:0] y0;

        iRST = 1'b1;
        iMode = 1'b0; iLast = 1'b0; iValid = 1'b0; iReady = 1'b0; iX = '0;
        s_mode = 1'b0; s_last = 1'b0; s_valid = 1'b0; s_iready = 1'b0; s_x = '0;
        repeat (3) step();
        check_cleared("reset");
        check("reset_small_y", s_y, '0);
        iRST = 1'b0;
        step();

        // Exact powers: c leading zeros give oValid in cycle c+35.
        run_single("one",  X_ONE,  '0,      1'b0, 66);
        run_single("two",  X_TWO,  Y_ONE,   1'b0, 65);
        run_single("half", X_HALF, Y_M_ONE, 1'b0, 67);

        // log2(3) = 1.5849625007 -> fraction 0x95C01A39.FB, truncation may lose 2 LSB.
        send(X_THREE, 1'b0, 1'b0);
        wait_valid(cyc);
        check("three_lat", cyc, 65);
        check("three_int", oY[OW-1:32], 40'd1);
        check("three_frac_window", (oY[31:0] >= 32'h95C0_1A37) && (oY[31:0] <= 32'h95C0_1A39), 1'b1);
        take();

        run_single("zero", '0, MINV, 1'b1, 2);

        acc_mid("acc_a", X_TWO, 65);
        acc_mid("acc_b", X_FOUR, 64);
        acc_last("acc_c", X_HALF, Y_TWO, 3, 1'b0, 67);

        acc_mid("accz_a", X_TWO, 65);
        acc_mid("accz_b", '0, 2);
        acc_last("accz_c", X_FOUR, MINV, 3, 1'b1, 64);

        // Reset while in FRAC: 3.0 leaves NORM after 31 cycles.
        send(X_THREE, 1'b0, 1'b0);
        repeat (40) step();
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        check_cleared("rst_frac");

        // Reset inside an open sequence; the next sequence must start from zero.
        acc_mid("rseq_a", X_TWO, 65);
        send(X_FOUR, 1'b1, 1'b0);
        repeat (10) step();
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        check_cleared("rst_seq");
        acc_last("rseq_fresh", X_HALF, Y_M_ONE, 1, 1'b0, 67);

        // A single-mode operand inside a sequence leaves the sum alone.
        acc_mid("mix_a", X_TWO, 65);
        run_single("mix_single", X_FOUR, Y_TWO, 1'b0, 64);
        acc_last("mix_c", X_HALF, '0, 2, 1'b0, 67);

        // Backpressure with a competing operand offered throughout.
        send(X_TWO, 1'b0, 1'b0);
        wait_valid(cyc);
        check("bp_y", oY, Y_ONE);
        y0     = oY;
        stable = 1'b1;
        iX     = X_FOUR;
        iMode  = 1'b0;
        iValid = 1'b1;
        repeat (20) begin
            stable &= oValid && (oY == y0) && !oReady;
            step();
        end
        stable &= oValid && (oY == y0) && !oReady;
        iValid = 1'b0;
        check("bp_stable", stable, 1'b1);
        take();
        check("bp_ready_after", oReady, 1'b1);
        check("bp_valid_after", oValid, 1'b0);

        // Small config sweep. Mantissa and squaring truncation each lose up
        // to ~1.4 LSB, so the result may sit up to 3 below the floor model.
        for (int x = 0; x < 256; x++) begin
            s_x     = SW'(x);
            s_mode  = 1'b0;
            s_valid = 1'b1;
            step();
            s_valid = 1'b0;
            cyc_s = 1;
            while (!s_ovalid && cyc_s < 100) begin
                step();
                cyc_s++;
            end
            if (x == 0) begin
                check("small_zero_y", s_y, 16'h8000);
                check("small_zero_neg", s_neg, 1'b1);
            end else begin
                r  = $ln(real'(x) / 16.0) / $ln(2.0) * 16.0;
                e  = int'($floor(r + 1.0e-9));
                sy = int'($signed(s_y));
                check($sformatf("small_x%0d_y%0d_floor%0d", x, sy, e),
                      (sy <= e) && (sy >= e - 3) && !s_neg, 1'b1);
            end
            if (x == 1) check("small_worst_lat", cyc_s, 14);
            if (x == 16) check("small_one_exact", s_y, '0);
            s_iready = 1'b1;
            step();
            s_iready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

endmodule
